keycode_event_ctrl: RTL and testbench
=====================================

Name: keycode_event_ctrl

Overview:
Converts the 8-bit keycode level driven by the keycode PIO into a queued stream of key events (PRESS, RELEASE, REPEAT) for game logic. Typematic repeat uses a programmable delay and period. The NIOS configures and monitors the block through a small Avalon-MM slave (4 word registers). Game logic pops events through a valid/ready interface.

Parameters:
CLK_PER_MS, 50000, clock cycles per 1 ms repeat tick (≥2)
FIFO_DEPTH, 8, event queue depth (power of 2, ≥2)

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
keycode  in  8  current keycode from PIO out_port; 0 = no key
address  in  2  CSR word address
chipselect  in  1  CSR select
write_n  in  1  CSR write strobe, active-low
writedata  in  32  CSR write data
readdata  out  32  CSR read data, combinational from address
ev_valid  out  1  event available (FIFO not empty)
ev_ready  in  1  consumer accepts event
ev_data  out  10  [9:8] type 01=PRESS 10=RELEASE 11=REPEAT; [7:0] code

Behaviour:
- Reset values: readdata = value of addressed reset register; ev_valid 0; ev_data 0; FIFO empty; FSM IDLE; kc_q 0; held_code 0; CTRL.repeat_en 1; DELAY 500; PERIOD 33; overflow 0.
- keycode is registered once (kc_q); all FSM decisions use kc_q.
- CSR map (write = chipselect & ~write_n):
  - 0 CTRL: bit0 repeat_en (R/W); bit1 flush (write 1 → FIFO emptied that cycle; reads 0).
  - 1 DELAY_MS [15:0] R/W.
  - 2 PERIOD_MS [15:0] R/W. A value of 0 in DELAY or PERIOD is treated as 1.
  - 3 STATUS (RO except bit8): [7:0] fill level; bit8 overflow (sticky; write 1 clears); bit9 empty.
  - Unused bits read 0.
- FSM states: IDLE, EMIT_PRS, HOLD, EMIT_REL, EMIT_RPT.
  - IDLE: kc_q≠0 → held_code<=kc_q, go EMIT_PRS.
  - EMIT_PRS: push {01,held_code} when FIFO not full (stall otherwise), then HOLD. On HOLD entry: prescaler 0, ms counter 0, threshold <= DELAY.
  - HOLD: kc_q≠held_code → EMIT_REL (priority over repeat). Else if repeat_en: prescaler counts 0..CLK_PER_MS-1 and ticks at wrap; ms counter increments on tick. At the tick bringing the ms counter to threshold → EMIT_RPT. repeat_en=0 freezes both counters.
  - EMIT_RPT: single cycle. Push {11,held_code} if not full; if full, drop and set overflow. Return to HOLD with counters cleared and threshold <= PERIOD.
  - EMIT_REL: push {10,held_code} when not full (stall otherwise). After the push: kc_q≠0 → held_code<=kc_q, EMIT_PRS; else IDLE.
- PRESS and RELEASE are never dropped; the FSM stalls until space. Only REPEAT can be dropped.
- CSR changes to DELAY/PERIOD apply at the next threshold load.
- Latency:
  - keycode change at cycle 0 → push at cycle 2 → ev_valid at cycle 3 (empty FIFO).
  - First REPEAT is pushed DELAY*CLK_PER_MS+1 cycles after the PRESS push cycle; subsequent REPEATs every PERIOD*CLK_PER_MS+1 cycles.
- FIFO:
  - First-word-fall-through; ev_data = head entry; pop on ev_valid & ev_ready.
  - Simultaneous push and pop when full is allowed; level unchanged.
  - Flush has priority over push/pop in the same cycle; the push is lost, the FSM still advances, and no overflow is flagged.
- Reset mid-operation clears everything immediately; no RELEASE is emitted for a held key.

Test Plan:
- CLK_PER_MS=4, DELAY=3, PERIOD=2: keycode 0→0x1A at cycle 0 → PRESS (0x11A) pushed cycle 2; REPEAT 0x31A pushed cycles 15, 24, 33.
- Held 0x1A, keycode →0x04 → RELEASE 0x21A then PRESS 0x104 on consecutive cycles; held 0x04 → 0 → RELEASE 0x204, FSM IDLE.
- ev_ready=0; generate FIFO_DEPTH events then hold key → STATUS fill 8, REPEATs dropped, overflow=1; write 0x100 to addr 3 → overflow 0.
- FIFO full during key change → FSM stalls in EMIT_REL; one pop → RELEASE enters the following cycle, then PRESS after the next pop; order preserved.
- CTRL repeat_en=0 while held → no REPEAT for 100 ms-equivalent; re-enable → first REPEAT after full DELAY from re-enable.
- Write CTRL=0x3 with 5 queued events → STATUS reads empty=1, level 0; reset_n pulse while HOLD → ev_valid 0, DELAY reads 500, PERIOD 33.

Source files
------------

// File: rtl/keycode_event_ctrl.sv
// keycode_event_ctrl: turns the PIO keycode level into a queued stream of
// PRESS / RELEASE / REPEAT events with programmable typematic timing.
// Configured over a 4-word Avalon-MM slave; events drain via valid/ready.
module keycode_event_ctrl #(
  parameter int CLK_PER_MS = 50000,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [7:0]  keycode,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        ev_valid,
  input  logic        ev_ready,
  output logic [9:0]  ev_data
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int LW = AW + 1;
  localparam int PW = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;

  localparam logic [1:0] T_PRS = 2'b01;
  localparam logic [1:0] T_REL = 2'b10;
  localparam logic [1:0] T_RPT = 2'b11;

  typedef struct packed {
    logic [1:0] typ;
    logic [7:0] code;
  } ev_t;

  typedef enum logic [2:0] {IDLE, EMIT_PRS, HOLD, EMIT_REL, EMIT_RPT} state_t;

  state_t         state, state_n;
  logic [7:0]     kc_q, held_code;
  logic           repeat_en, overflow;
  logic [15:0]    delay_ms, period_ms, thr, ms_cnt;
  logic [PW-1:0]  pre_cnt;
  logic           tick;

  // FSM outputs
  logic           push, held_ld, clr_cnt, ld_dly, ld_per, ovf_set;
  logic [1:0]     push_typ;

  // FIFO
  ev_t            mem [FIFO_DEPTH];
  logic [AW-1:0]  wr_ptr, rd_ptr;
  logic [LW-1:0]  level;
  logic           full, empty, wr_en, rd_en;

  // CSR decode
  logic           csr_wr, flush, ovf_clr;
  logic [7:0]     lvl8;
  logic           unused_wdata;

  assign csr_wr       = chipselect & ~write_n;
  assign flush        = csr_wr & (address == 2'd0) & writedata[1];
  assign ovf_clr      = csr_wr & (address == 2'd3) & writedata[8];
  assign unused_wdata = ^writedata[31:16];

  assign full  = (level == LW'(FIFO_DEPTH));
  assign empty = (level == '0);
  assign tick  = (pre_cnt == PW'(CLK_PER_MS - 1));

  // Flush wins over any push/pop in the same cycle
  assign wr_en = push & ~flush & (~full | rd_en);
  assign rd_en = ev_valid & ev_ready & ~flush;

  assign ev_valid = ~empty;
  assign ev_data  = empty ? 10'd0 : mem[rd_ptr];
  assign lvl8     = 8'(level);

  // Keycode input register; all decisions are made on kc_q
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) kc_q <= '0;
    else          kc_q <= keycode;
  end

  // CSR registers and sticky overflow (a new drop beats a clear)
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      repeat_en <= 1'b1;
      delay_ms  <= 16'd500;
      period_ms <= 16'd33;
      overflow  <= 1'b0;
    end else begin
      if (csr_wr && address == 2'd0) repeat_en <= writedata[0];
      if (csr_wr && address == 2'd1) delay_ms  <= writedata[15:0];
      if (csr_wr && address == 2'd2) period_ms <= writedata[15:0];
      if (ovf_set && !flush)         overflow  <= 1'b1;
      else if (ovf_clr)              overflow  <= 1'b0;
    end
  end

  // CSR read mux
  always_comb begin
    readdata = '0;
    case (address)
      2'd0: readdata = {31'd0, repeat_en};
      2'd1: readdata = {16'd0, delay_ms};
      2'd2: readdata = {16'd0, period_ms};
      2'd3: readdata = {22'd0, empty, overflow, lvl8};
      default: readdata = '0;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_n;
  end

  // FSM next-state and push control
  always_comb begin
    state_n  = state;
    push     = 1'b0;
    push_typ = T_PRS;
    held_ld  = 1'b0;
    clr_cnt  = 1'b0;
    ld_dly   = 1'b0;
    ld_per   = 1'b0;
    ovf_set  = 1'b0;
    case (state)
      IDLE: if (kc_q != 8'd0) begin
        held_ld = 1'b1;
        state_n = EMIT_PRS;
      end
      EMIT_PRS: if (!full) begin
        push    = 1'b1;
        clr_cnt = 1'b1;
        ld_dly  = 1'b1;
        state_n = HOLD;
      end
      HOLD: begin
        if (kc_q != held_code)
          state_n = EMIT_REL;
        else if (repeat_en && tick && (ms_cnt + 16'd1 == thr))
          state_n = EMIT_RPT;
      end
      EMIT_RPT: begin
        push_typ = T_RPT;
        push     = ~full;
        ovf_set  = full;
        clr_cnt  = 1'b1;
        ld_per   = 1'b1;
        state_n  = HOLD;
      end
      EMIT_REL: begin
        push_typ = T_REL;
        if (!full) begin
          push = 1'b1;
          if (kc_q != 8'd0) begin
            held_ld = 1'b1;
            state_n = EMIT_PRS;
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Held code, repeat threshold and typematic counters
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      held_code <= '0;
      thr       <= 16'd1;
      pre_cnt   <= '0;
      ms_cnt    <= '0;
    end else begin
      if (held_ld) held_code <= kc_q;
      if (ld_dly)  thr <= (delay_ms  == 16'd0) ? 16'd1 : delay_ms;
      if (ld_per)  thr <= (period_ms == 16'd0) ? 16'd1 : period_ms;
      if (clr_cnt) begin
        pre_cnt <= '0;
        ms_cnt  <= '0;
      end else if (state == HOLD && repeat_en) begin
        pre_cnt <= tick ? '0 : pre_cnt + PW'(1);
        if (tick) ms_cnt <= ms_cnt + 16'd1;
      end
    end
  end

  // FIFO storage (no reset needed; ev_data is masked while empty)
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= '{typ: push_typ, code: held_code};
  end

  // FIFO pointers and fill level
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (rd_en) rd_ptr <= rd_ptr + AW'(1);
      case ({wr_en, rd_en})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: tb/tb_keycode_event_ctrl.sv
// Directed bench for keycode_event_ctrl with CLK_PER_MS=4, FIFO_DEPTH=8.
module tb_keycode_event_ctrl;
  localparam int CPM   = 4;
  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [7:0]  keycode = 8'd0;
  logic [1:0]  address = 2'd0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = 32'd0;
  logic [31:0] readdata;
  logic        ev_valid;
  logic        ev_ready = 1'b0;
  logic [9:0]  ev_data;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int pop_cyc[$];
  logic [9:0] pop_dat[$];

  keycode_event_ctrl #(.CLK_PER_MS(CPM), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n), .keycode(keycode), .address(address),
    .chipselect(chipselect), .write_n(write_n), .writedata(writedata),
    .readdata(readdata), .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_data(ev_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Pop log: entry is the posedge at which the pop takes effect
  always @(negedge clk)
    if (reset_n && ev_valid && ev_ready) begin
      pop_cyc.push_back(cyc + 1);
      pop_dat.push_back(ev_data);
    end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic csr_wr(input logic [1:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    tick();
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic csr_rd(input logic [1:0] a, output logic [31:0] d);
    address = a;
    #1;
    d = readdata;
  endtask

  task automatic set_key(input logic [7:0] k, output int t);
    keycode = k;
    t = cyc + 1;
  endtask

  task automatic wait_pops(input int n, input int budget);
    int b = 0;
    while (pop_cyc.size() < n && b < budget) begin
      tick();
      b++;
    end
  endtask

  task automatic clr_log();
    pop_cyc.delete();
    pop_dat.delete();
  endtask

  task automatic test_reset();
    logic [31:0] d;
    tick(2);
    reset_n = 1'b1;
    tick();
    n_chk++; if (ev_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b want 0", ev_valid); end
    n_chk++; if (ev_data !== 10'd0) begin n_fail++; $display("FAIL rst_data: got %h want 000", ev_data); end
    csr_rd(0, d); n_chk++; if (d !== 32'h1) begin n_fail++; $display("FAIL rst_ctrl: got %h want 1", d); end
    csr_rd(1, d); n_chk++; if (d !== 32'd500) begin n_fail++; $display("FAIL rst_delay: got %0d want 500", d); end
    csr_rd(2, d); n_chk++; if (d !== 32'd33) begin n_fail++; $display("FAIL rst_period: got %0d want 33", d); end
    csr_rd(3, d); n_chk++; if (d !== 32'h200) begin n_fail++; $display("FAIL rst_status: got %h want 200", d); end
  endtask

  task automatic test_csr();
    logic [31:0] d;
    csr_wr(1, 32'hABCD_0003);
    csr_wr(2, 32'd2);
    csr_rd(1, d); n_chk++; if (d !== 32'd3) begin n_fail++; $display("FAIL csr_delay: got %h want 3", d); end
    csr_rd(2, d); n_chk++; if (d !== 32'd2) begin n_fail++; $display("FAIL csr_period: got %h want 2", d); end
  endtask

  task automatic test_press_repeat();
    int t0;
    int off[4];
    logic [9:0] dat[4];
    off = '{3, 16, 25, 34};
    dat = '{10'h11A, 10'h31A, 10'h31A, 10'h31A};
    clr_log();
    ev_ready = 1'b1;
    set_key(8'h1A, t0);
    wait_pops(4, 60);
    n_chk++; if (pop_cyc.size() != 4) begin n_fail++; $display("FAIL pr_count: got %0d want 4", pop_cyc.size()); end
    for (int i = 0; i < 4 && i < pop_cyc.size(); i++) begin
      n_chk++;
      if (pop_cyc[i] != t0 + off[i] || pop_dat[i] !== dat[i]) begin
        n_fail++;
        $display("FAIL pr_ev%0d: got %h@%0d want %h@%0d", i, pop_dat[i], pop_cyc[i] - t0, dat[i], off[i]);
      end
    end
  endtask

  task automatic test_key_change();
    int t1, t2;
    clr_log();
    set_key(8'h04, t1);
    wait_pops(2, 20);
    n_chk++; if (pop_cyc.size() != 2) begin n_fail++; $display("FAIL kc_count: got %0d want 2", pop_cyc.size()); end
    if (pop_cyc.size() >= 2) begin
      n_chk++; if (pop_cyc[0] != t1 + 3 || pop_dat[0] !== 10'h21A) begin n_fail++; $display("FAIL kc_rel: got %h@%0d want 21a@3", pop_dat[0], pop_cyc[0] - t1); end
      n_chk++; if (pop_cyc[1] != t1 + 4 || pop_dat[1] !== 10'h104) begin n_fail++; $display("FAIL kc_prs: got %h@%0d want 104@4", pop_dat[1], pop_cyc[1] - t1); end
    end
    clr_log();
    set_key(8'h00, t2);
    wait_pops(1, 20);
    n_chk++; if (pop_cyc.size() != 1) begin n_fail++; $display("FAIL kc_rel0_count: got %0d want 1", pop_cyc.size()); end
    if (pop_cyc.size() >= 1) begin
      n_chk++; if (pop_cyc[0] != t2 + 3 || pop_dat[0] !== 10'h204) begin n_fail++; $display("FAIL kc_rel0: got %h@%0d want 204@3", pop_dat[0], pop_cyc[0] - t2); end
    end
    tick(30);
    n_chk++; if (pop_cyc.size() != 1 || ev_valid !== 1'b0) begin n_fail++; $display("FAIL kc_idle: got %0d events valid=%b want 1 events valid=0", pop_cyc.size(), ev_valid); end
  endtask

  task automatic test_overflow();
    logic [31:0] d;
    int t, b;
    clr_log();
    ev_ready = 1'b0;
    set_key(8'h22, t);
    b = 0;
    csr_rd(3, d);
    while (d[7:0] != 8'd8 && b < 200) begin
      tick();
      csr_rd(3, d);
      b++;
    end
    tick(20);
    csr_rd(3, d); n_chk++; if (d !== 32'h108) begin n_fail++; $display("FAIL ov_status: got %h want 108", d); end
    n_chk++; if (ev_valid !== 1'b1 || ev_data !== 10'h122) begin n_fail++; $display("FAIL ov_head: got %b/%h want 1/122", ev_valid, ev_data); end
    csr_wr(0, 32'h0);
    csr_wr(3, 32'h100);
    csr_rd(3, d); n_chk++; if (d !== 32'h008) begin n_fail++; $display("FAIL ov_clear: got %h want 008", d); end
  endtask

  task automatic test_full_stall();
    logic [31:0] d;
    logic [9:0] exp[10];
    int t;
    exp[0] = 10'h122;
    for (int i = 1; i < 8; i++) exp[i] = 10'h322;
    exp[8] = 10'h222;
    exp[9] = 10'h133;
    set_key(8'h33, t);
    tick(6);
    csr_rd(3, d); n_chk++; if (d !== 32'h008) begin n_fail++; $display("FAIL fs_stall: got %h want 008", d); end
    clr_log();
    ev_ready = 1'b1; tick(); ev_ready = 1'b0;
    csr_rd(3, d); n_chk++; if (d !== 32'h007) begin n_fail++; $display("FAIL fs_pop1: got %h want 007", d); end
    tick();
    csr_rd(3, d); n_chk++; if (d !== 32'h008) begin n_fail++; $display("FAIL fs_rel_in: got %h want 008", d); end
    tick(3);
    ev_ready = 1'b1; tick(); ev_ready = 1'b0;
    tick();
    csr_rd(3, d); n_chk++; if (d !== 32'h008) begin n_fail++; $display("FAIL fs_prs_in: got %h want 008", d); end
    ev_ready = 1'b1;
    wait_pops(10, 40);
    n_chk++; if (pop_cyc.size() != 10) begin n_fail++; $display("FAIL fs_count: got %0d want 10", pop_cyc.size()); end
    for (int i = 0; i < 10 && i < pop_dat.size(); i++) begin
      n_chk++; if (pop_dat[i] !== exp[i]) begin n_fail++; $display("FAIL fs_order%0d: got %h want %h", i, pop_dat[i], exp[i]); end
    end
    tick(2);
    n_chk++; if (ev_valid !== 1'b0) begin n_fail++; $display("FAIL fs_drained: got %b want 0", ev_valid); end
  endtask

  task automatic test_repeat_enable();
    int n;
    clr_log();
    ev_ready = 1'b1;
    tick(100 * CPM);
    n_chk++; if (pop_cyc.size() != 0) begin n_fail++; $display("FAIL re_frozen: got %0d events want 0", pop_cyc.size()); end
    n = cyc;
    csr_wr(0, 32'h1);
    wait_pops(1, 40);
    n_chk++; if (pop_cyc.size() != 1) begin n_fail++; $display("FAIL re_count: got %0d want 1", pop_cyc.size()); end
    if (pop_cyc.size() >= 1) begin
      n_chk++; if (pop_cyc[0] != n + 15 || pop_dat[0] !== 10'h333) begin n_fail++; $display("FAIL re_first: got %h@%0d want 333@15", pop_dat[0], pop_cyc[0] - n); end
    end
    csr_wr(0, 32'h0);
  endtask

  task automatic test_flush();
    logic [31:0] d;
    int t;
    ev_ready = 1'b0;
    tick(2);
    clr_log();
    set_key(8'h41, t); tick(6);
    set_key(8'h42, t); tick(6);
    set_key(8'h00, t); tick(6);
    csr_rd(3, d); n_chk++; if (d !== 32'h005) begin n_fail++; $display("FAIL fl_level: got %h want 005", d); end
    n_chk++; if (ev_data !== 10'h233) begin n_fail++; $display("FAIL fl_head: got %h want 233", ev_data); end
    csr_wr(0, 32'h3);
    csr_rd(3, d); n_chk++; if (d !== 32'h200) begin n_fail++; $display("FAIL fl_status: got %h want 200", d); end
    n_chk++; if (ev_valid !== 1'b0) begin n_fail++; $display("FAIL fl_valid: got %b want 0", ev_valid); end
    csr_rd(0, d); n_chk++; if (d !== 32'h1) begin n_fail++; $display("FAIL fl_ctrl: got %h want 1", d); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    int t;
    csr_wr(1, 32'd7);
    ev_ready = 1'b0;
    set_key(8'h55, t);
    tick(6);
    n_chk++; if (ev_valid !== 1'b1 || ev_data !== 10'h155) begin n_fail++; $display("FAIL rm_pre: got %b/%h want 1/155", ev_valid, ev_data); end
    reset_n = 1'b0;
    keycode = 8'h00;
    #1;
    n_chk++; if (ev_valid !== 1'b0 || ev_data !== 10'd0) begin n_fail++; $display("FAIL rm_valid: got %b/%h want 0/000", ev_valid, ev_data); end
    csr_rd(1, d); n_chk++; if (d !== 32'd500) begin n_fail++; $display("FAIL rm_delay: got %0d want 500", d); end
    csr_rd(2, d); n_chk++; if (d !== 32'd33) begin n_fail++; $display("FAIL rm_period: got %0d want 33", d); end
    csr_rd(3, d); n_chk++; if (d !== 32'h200) begin n_fail++; $display("FAIL rm_status: got %h want 200", d); end
    tick(2);
    reset_n = 1'b1;
    tick();
    clr_log();
    ev_ready = 1'b1;
    tick(20);
    n_chk++; if (pop_cyc.size() != 0) begin n_fail++; $display("FAIL rm_norel: got %0d events want 0", pop_cyc.size()); end
  endtask

  task automatic test_zero_delay();
    logic [31:0] d;
    int t;
    int off[3];
    logic [9:0] dat[3];
    off = '{3, 8, 13};
    dat = '{10'h166, 10'h366, 10'h366};
    csr_wr(1, 32'd0);
    csr_wr(2, 32'd0);
    csr_rd(1, d); n_chk++; if (d !== 32'd0) begin n_fail++; $display("FAIL zd_read: got %h want 0", d); end
    clr_log();
    ev_ready = 1'b1;
    set_key(8'h66, t);
    wait_pops(3, 40);
    n_chk++; if (pop_cyc.size() != 3) begin n_fail++; $display("FAIL zd_count: got %0d want 3", pop_cyc.size()); end
    for (int i = 0; i < 3 && i < pop_cyc.size(); i++) begin
      n_chk++;
      if (pop_cyc[i] != t + off[i] || pop_dat[i] !== dat[i]) begin
        n_fail++;
        $display("FAIL zd_ev%0d: got %h@%0d want %h@%0d", i, pop_dat[i], pop_cyc[i] - t, dat[i], off[i]);
      end
    end
    keycode = 8'h00;
    tick(5);
  endtask

  initial begin
    test_reset();
    test_csr();
    test_press_repeat();
    test_key_change();
    test_overflow();
    test_full_stall();
    test_repeat_enable();
    test_flush();
    test_reset_mid();
    test_zero_delay();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
